// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Optional macro EX_PC_SRC_EN adds ALUSrcAD so operand A can take the PC (AUIPC/JAL).
module id_ex_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [2:0]            ALUControlD,
    input  logic                  ALUSrcD,
`ifdef EX_PC_SRC_EN
    input  logic                  ALUSrcAD,
`endif
    input  logic                  RegWriteD,
    input  logic                  MemReadD,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    output logic [DATA_WIDTH-1:0] SrcAE,
    output logic [DATA_WIDTH-1:0] SrcBE,
    output logic [2:0]            ALUControlE,
    output logic [DATA_WIDTH-1:0] WriteDataE,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  RegWriteE,
    output logic                  MemReadE,
    output logic                  ValidE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  LoadUseStall
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] rd1_r;
    logic [DATA_WIDTH-1:0] rd2_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] imm_r;
    logic [REG_ADDR_W-1:0] rs1_r;
    logic [REG_ADDR_W-1:0] rs2_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [2:0]            alu_ctrl_r;
    logic                  alu_src_r;
    logic                  reg_write_r;
    logic                  mem_read_r;
`ifdef EX_PC_SRC_EN
    logic                  alu_src_a_r;
`endif
    logic                  load_use_s;
    logic [DATA_WIDTH-1:0] fwd_a_s;
    logic [DATA_WIDTH-1:0] fwd_b_s;

    // MEM is checked first so the newest in-flight value wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic                  we_m,
                                           input logic [REG_ADDR_W-1:0] rd_m,
                                           input logic                  we_w,
                                           input logic [REG_ADDR_W-1:0] rd_w,
                                           input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        if (we_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fwd_mux(input logic [1:0]            sel,
                                                      input logic [DATA_WIDTH-1:0] reg_val,
                                                      input logic [DATA_WIDTH-1:0] w_val,
                                                      input logic [DATA_WIDTH-1:0] m_val);
        logic [DATA_WIDTH-1:0] val;
        case (sel)
            2'b10:   val = m_val;
            2'b01:   val = w_val;
            2'b00:   val = reg_val;
            default: val = reg_val;
        endcase
        return val;
    endfunction

    // Load-use detection looks only at E state and D inputs, never at StallE.
    assign load_use_s = valid_r & mem_read_r & (rd_r != REG_ZERO) &
                        ((rd_r == Rs1D) | (rd_r == Rs2D)) & ValidD;

    // E-stage register: reset > bubble > hold > capture.
    always_ff @(posedge clk) begin
        if (rst || FlushE || load_use_s) begin
            valid_r     <= 1'b0;
            rd1_r       <= DATA_ZERO;
            rd2_r       <= DATA_ZERO;
            pc_r        <= DATA_ZERO;
            imm_r       <= DATA_ZERO;
            rs1_r       <= REG_ZERO;
            rs2_r       <= REG_ZERO;
            rd_r        <= REG_ZERO;
            alu_ctrl_r  <= 3'b000;
            alu_src_r   <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
`ifdef EX_PC_SRC_EN
            alu_src_a_r <= 1'b0;
`endif
        end else if (StallE) begin
            valid_r     <= valid_r;
        end else begin
            valid_r     <= ValidD;
            rd1_r       <= RD1D;
            rd2_r       <= RD2D;
            pc_r        <= PCD;
            imm_r       <= ImmExtD;
            rs1_r       <= Rs1D;
            rs2_r       <= Rs2D;
            rd_r        <= RdD;
            alu_ctrl_r  <= ALUControlD;
            alu_src_r   <= ALUSrcD;
            reg_write_r <= RegWriteD;
            mem_read_r  <= MemReadD;
`ifdef EX_PC_SRC_EN
            alu_src_a_r <= ALUSrcAD;
`endif
        end
    end

    // Forward selects and operand muxing on the registered fields.
    always_comb begin
        ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, rs1_r);
        ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, rs2_r);
        fwd_a_s   = fwd_mux(ForwardAE, rd1_r, ResultW, ALUResultM);
        fwd_b_s   = fwd_mux(ForwardBE, rd2_r, ResultW, ALUResultM);
        WriteDataE = fwd_b_s;
`ifdef EX_PC_SRC_EN
        if (alu_src_a_r) begin
            SrcAE = pc_r;
        end else begin
            SrcAE = fwd_a_s;
        end
`else
        SrcAE = fwd_a_s;
`endif
        if (alu_src_r) begin
            SrcBE = imm_r;
        end else begin
            SrcBE = fwd_b_s;
        end
    end

    assign ALUControlE  = alu_ctrl_r;
    assign RdE          = rd_r;
    assign RegWriteE    = reg_write_r;
    assign MemReadE     = mem_read_r;
    assign ValidE       = valid_r;
    assign PCE          = pc_r;
    assign LoadUseStall = load_use_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: table of forwarding vectors through a
// scoreboard queue, plus hand sequences for reset, load-use, stall/flush and EX_PC_SRC_EN.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, StallE, FlushE, ValidD;
    logic [31:0] RD1D, RD2D, PCD, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegWriteD, MemReadD;
`ifdef EX_PC_SRC_EN
    logic        ALUSrcAD;
`endif
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, ValidE, LoadUseStall;
    logic [1:0]  ForwardAE, ForwardBE;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD),
`ifdef EX_PC_SRC_EN
        .ALUSrcAD(ALUSrcAD),
`endif
        .RegWriteD(RegWriteD), .MemReadD(MemReadD),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .ValidE(ValidE),
        .PCE(PCE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LoadUseStall(LoadUseStall)
    );

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  aluc;
        logic        alusrc;
        logic [31:0] alum;
        logic [4:0]  rdm;
        logic        rwm;
        logic [31:0] resw;
        logic [4:0]  rdw;
        logic        rww;
        logic [1:0]  efa, efb;
        logic [31:0] esa, esb, ewd;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    vec_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_fwd();
        RegWriteM = 1'b0; RdM = 5'd0; ALUResultM = 32'h0;
        RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
    endtask

    task automatic drive_d(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [2:0] aluc, input logic alusrc,
                           input logic rw, input logic mr);
        ValidD = 1'b1; RD1D = rd1; RD2D = rd2; ImmExtD = imm; PCD = pc;
        Rs1D = rs1; Rs2D = rs2; RdD = rd; ALUControlD = aluc; ALUSrcD = alusrc;
        RegWriteD = rw; MemReadD = mr;
    endtask

    initial begin
        // rd1 rd2 imm pc rs1 rs2 rd aluc alusrc | alum rdm rwm | resw rdw rww | fa fb sa sb wd
        vecs[0] = '{32'h5, 32'h7, 32'h0, 32'h10, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0,
                    32'h99, 5'd9, 1'b1, 32'h88, 5'd8, 1'b1, 2'b00, 2'b00, 32'h5, 32'h7, 32'h7};
        vecs[1] = '{32'hA, 32'hB, 32'h0, 32'h14, 5'd3, 5'd6, 5'd4, 3'b001, 1'b0,
                    32'h11, 5'd3, 1'b1, 32'h22, 5'd3, 1'b1, 2'b10, 2'b00, 32'h11, 32'hB, 32'hB};
        vecs[2] = '{32'hA, 32'hB, 32'h0, 32'h18, 5'd3, 5'd6, 5'd4, 3'b001, 1'b0,
                    32'h11, 5'd3, 1'b0, 32'h22, 5'd3, 1'b1, 2'b01, 2'b00, 32'h22, 32'hB, 32'hB};
        vecs[3] = '{32'h1, 32'h2, 32'hFFFFFFFC, 32'h1C, 5'd0, 5'd0, 5'd5, 3'b010, 1'b1,
                    32'h33, 5'd0, 1'b1, 32'h44, 5'd0, 1'b1, 2'b00, 2'b00, 32'h1, 32'hFFFFFFFC, 32'h2};
        vecs[4] = '{32'h70, 32'h50, 32'h1234, 32'h20, 5'd7, 5'd5, 5'd6, 3'b011, 1'b1,
                    32'h9, 5'd9, 1'b1, 32'h5555, 5'd5, 1'b1, 2'b00, 2'b01, 32'h70, 32'h1234, 32'h5555};
        vecs[5] = '{32'h1, 32'h2, 32'h0, 32'h24, 5'd12, 5'd13, 5'd14, 3'b101, 1'b0,
                    32'hDEAD, 5'd13, 1'b1, 32'hBEEF, 5'd12, 1'b1, 2'b01, 2'b10, 32'hBEEF, 32'hDEAD, 32'hDEAD};
        vecs[6] = '{32'h3, 32'h4, 32'h0, 32'h28, 5'd31, 5'd31, 5'd1, 3'b000, 1'b0,
                    32'hCAFE, 5'd31, 1'b1, 32'h1, 5'd31, 1'b0, 2'b10, 2'b10, 32'hCAFE, 32'hCAFE, 32'hCAFE};
        vecs[7] = '{32'h80, 32'h81, 32'h0, 32'h2C, 5'd8, 5'd8, 5'd2, 3'b001, 1'b0,
                    32'h66, 5'd8, 1'b0, 32'h77, 5'd8, 1'b0, 2'b00, 2'b00, 32'h80, 32'h81, 32'h81};

        StallE = 1'b0; FlushE = 1'b0;
`ifdef EX_PC_SRC_EN
        ALUSrcAD = 1'b0;
`endif
        idle_fwd();

        // Reset with random D inputs.
        rst = 1'b1;
        drive_d($urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 1'($urandom), 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, ValidE}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("rst_memread", {31'd0, MemReadE}, 32'd0);
        chk("rst_aluctl", {29'd0, ALUControlE}, 32'd0);
        chk("rst_pc", PCE, 32'd0);
        chk("rst_rd", {27'd0, RdE}, 32'd0);

        // Release reset and capture the first instruction.
        rst = 1'b0;
        drive_d(32'd5, 32'd7, 32'd0, 32'h4, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 ValidD = 1'b0;
        @(negedge clk);
        chk("rel_srca", SrcAE, 32'd5);
        chk("rel_srcb", SrcBE, 32'd7);
        chk("rel_valid", {31'd0, ValidE}, 32'd1);

        // Forwarding table through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            drive_d(vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].pc, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].rd, vecs[i].aluc, vecs[i].alusrc, 1'b1, 1'b0);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            ValidD = 1'b0;
            ALUResultM = vecs[i].alum; RdM = vecs[i].rdm; RegWriteM = vecs[i].rwm;
            ResultW = vecs[i].resw; RdW = vecs[i].rdw; RegWriteW = vecs[i].rww;
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d_fa", i), {30'd0, ForwardAE}, {30'd0, e.efa});
            chk($sformatf("v%0d_fb", i), {30'd0, ForwardBE}, {30'd0, e.efb});
            chk($sformatf("v%0d_srca", i), SrcAE, e.esa);
            chk($sformatf("v%0d_srcb", i), SrcBE, e.esb);
            chk($sformatf("v%0d_wdata", i), WriteDataE, e.ewd);
            chk($sformatf("v%0d_rd", i), {27'd0, RdE}, {27'd0, e.rd});
            chk($sformatf("v%0d_aluc", i), {29'd0, ALUControlE}, {29'd0, e.aluc});
            chk($sformatf("v%0d_pc", i), PCE, e.pc);
            chk($sformatf("v%0d_lus", i), {31'd0, LoadUseStall}, 32'd0);
        end
        idle_fwd();

        // Load-use: load to x4 in E, consumer reads x4 as rs2.
        drive_d(32'h0, 32'h0, 32'h0, 32'h40, 5'd1, 5'd2, 5'd4, 3'b000, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive_d(32'h0, 32'h0, 32'h0, 32'h44, 5'd9, 5'd4, 5'd6, 3'b000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lu_memread", {31'd0, MemReadE}, 32'd1);
        chk("lu_stall", {31'd0, LoadUseStall}, 32'd1);
        @(negedge clk);
        chk("lu_bubble_valid", {31'd0, ValidE}, 32'd0);
        chk("lu_bubble_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("lu_stall_clear", {31'd0, LoadUseStall}, 32'd0);
        @(negedge clk);
        chk("lu_consumer_rd", {27'd0, RdE}, 32'd6);
        // A load to x0 never stalls.
        drive_d(32'h0, 32'h0, 32'h0, 32'h48, 5'd1, 5'd2, 5'd0, 3'b000, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive_d(32'h0, 32'h0, 32'h0, 32'h4C, 5'd0, 5'd0, 5'd7, 3'b000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lu_x0", {31'd0, LoadUseStall}, 32'd0);

        // Stall holds, stall+flush bubbles.
        drive_d(32'h0, 32'h0, 32'h0, 32'h200, 5'd1, 5'd2, 5'd10, 3'b011, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 drive_d(32'h0, 32'h0, 32'h0, 32'h300, 5'd1, 5'd2, 5'd11, 3'b001, 1'b0, 1'b0, 1'b0);
        StallE = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_rd", {27'd0, RdE}, 32'd10);
        chk("stall_pc", PCE, 32'h200);
        chk("stall_aluc", {29'd0, ALUControlE}, 32'd3);
        chk("stall_valid", {31'd0, ValidE}, 32'd1);
        FlushE = 1'b1;
        @(negedge clk);
        chk("flush_valid", {31'd0, ValidE}, 32'd0);
        chk("flush_pc", PCE, 32'd0);
        FlushE = 1'b0; StallE = 1'b0;
        @(negedge clk);
        chk("resume_pc", PCE, 32'h300);
        StallE = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_in_stall_pc", PCE, 32'd0);
        rst = 1'b0; StallE = 1'b0;

`ifdef EX_PC_SRC_EN
        drive_d(32'h55, 32'h66, 32'h2000, 32'h100, 5'd3, 5'd2, 5'd1, 3'b000, 1'b1, 1'b1, 1'b0);
        ALUSrcAD = 1'b1;
        @(posedge clk);
        #1 ValidD = 1'b0; ALUSrcAD = 1'b0;
        RdM = 5'd3; RegWriteM = 1'b1; ALUResultM = 32'h77;
        @(negedge clk);
        chk("pcsrc_srca", SrcAE, 32'h100);
        chk("pcsrc_srcb", SrcBE, 32'h2000);
        chk("pcsrc_fa", {30'd0, ForwardAE}, 32'd2);
        idle_fwd();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding, sitting directly upstream of the ALU in the 5-stage core.
- Captures decoded operands and control at the decode/execute boundary, and resolves RAW hazards from the MEM and WB stages.
- Drives the ALU's SrcA, SrcB and ALUControl, and flags load-use hazards so decode can stall.

Parameters:
- DATA_WIDTH, 32, width of operands, PC and immediate.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- StallE  in  1  hold all E-stage registers.
- FlushE  in  1  insert a bubble into E (branch taken).
- ValidD  in  1  decode stage holds a real instruction.
- RD1D  in  DATA_WIDTH  rs1 read data.
- RD2D  in  DATA_WIDTH  rs2 read data.
- PCD  in  DATA_WIDTH  instruction PC.
- ImmExtD  in  DATA_WIDTH  extended immediate.
- Rs1D  in  REG_ADDR_W  source register index 1.
- Rs2D  in  REG_ADDR_W  source register index 2.
- RdD  in  REG_ADDR_W  destination register index.
- ALUControlD  in  3  ALU op code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrcD  in  1  1 = SrcB takes the immediate.
- RegWriteD  in  1  instruction writes rd.
- MemReadD  in  1  instruction is a load.
- ALUResultM  in  DATA_WIDTH  MEM-stage result, forward source.
- RdM  in  REG_ADDR_W  MEM-stage destination register.
- RegWriteM  in  1  MEM-stage write enable.
- ResultW  in  DATA_WIDTH  WB-stage result, forward source.
- RdW  in  REG_ADDR_W  WB-stage destination register.
- RegWriteW  in  1  WB-stage write enable.
- SrcAE  out  DATA_WIDTH  ALU operand A.
- SrcBE  out  DATA_WIDTH  ALU operand B.
- ALUControlE  out  3  registered ALU op.
- WriteDataE  out  DATA_WIDTH  forwarded rs2 value (store data).
- RdE  out  REG_ADDR_W  registered destination register.
- RegWriteE  out  1  registered write enable.
- MemReadE  out  1  registered load flag.
- ValidE  out  1  E stage holds a real instruction.
- PCE  out  DATA_WIDTH  registered PC.
- ForwardAE  out  2  operand A forward select: 00 register, 01 WB, 10 MEM.
- ForwardBE  out  2  operand B forward select, same encoding.
- LoadUseStall  out  1  to hazard control: stall F/D.

Behaviour:
- Registered E fields, updated each clk edge with priority rst > flush > StallE > load:
  - rst: every E register is 0, so ValidE=0, RegWriteE=0, MemReadE=0, ALUControlE=000, RdE=0, PCE=0. SrcAE, SrcBE and WriteDataE then follow the forwarding rules below.
  - flush (FlushE | LoadUseStall): all E registers are cleared to 0, as at reset, producing a bubble.
  - StallE alone: hold all values.
  - Otherwise: capture the D inputs, with ValidE<=ValidD.
  - StallE and flush together: flush wins.
  - A reset asserted mid-stall clears immediately at the next edge.
- Forwarding is combinational on the registered fields, adding zero latency. For operand A:
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - else 00.
  - When M and W both match, M wins (newest value).
  - A destination of x0 is never forwarded.
- ForwardBE follows the same rules against Rs2E.
- Operand values:
  - fwdA/fwdB = mux(RD1E/RD2E, ResultW, ALUResultM) per the select.
  - SrcAE=fwdA. SrcBE = ALUSrcE ? ImmExtE : fwdB.
  - WriteDataE=fwdB always, independent of ALUSrcE.
  - ForwardBE is reported even when ALUSrcE=1.
- LoadUseStall (combinational) = ValidE & MemReadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & ValidD.
  - When asserted, the stage itself bubbles E at the next edge.
  - It must not depend on StallE, which avoids a combinational loop.
- No arithmetic is performed; all widths pass through unchanged.

Optional Feature:
- Macro EX_PC_SRC_EN.
- With the macro: input port ALUSrcAD (1 bit) is added and registered like the other control fields (reset 0, cleared on flush). When ALUSrcAE=1, SrcAE=PCE (AUIPC/JAL); ForwardAE is still computed and reported.
- Without the macro: the port is absent and SrcAE is always fwdA.

Test Plan:
- Reset: rst=1 for 2 cycles with random D inputs -> ValidE=0, RegWriteE=0, ALUControlE=000, PCE=0. Release with ValidD=1, RD1D=5, RD2D=7, ALUSrcD=0 -> next cycle SrcAE=5, SrcBE=7.
- MEM forward priority: Rs1E=3, RdM=3, RegWriteM=1, ALUResultM=0x11, RdW=3, RegWriteW=1, ResultW=0x22 -> ForwardAE=10, SrcAE=0x11. With RegWriteM=0 -> ForwardAE=01, SrcAE=0x22.
- x0 guard: Rs2E=0, RdM=0, RegWriteM=1 -> ForwardBE=00. ALUSrcE=1, ImmExtE=0xFFFFFFFC -> SrcBE=0xFFFFFFFC, WriteDataE=RD2E.
- Load-use: E holds a load with RdE=4; D has Rs2D=4 -> LoadUseStall=1. Next cycle ValidE=0, RegWriteE=0.
- Stall/flush: StallE=1 for 3 cycles -> E fields unchanged. StallE=1 and FlushE=1 together -> bubble (ValidE=0).
- EX_PC_SRC_EN: ALUSrcAD=1, PCD=0x100, ImmExtD=0x2000 -> SrcAE=0x100, SrcBE=0x2000.
